datasg_mc: RTL

DATASG_MC -- requirements
Module: datasg_mc

---
 rtl/datasg_mc_pkg.sv | 26 ++
 rtl/datasg_region_tracker.sv | 57 +++++
 rtl/datasg_mc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/datasg_mc_pkg.sv
// Shared definitions for the scatter/gather SRAM write controller:
// state encoding, header field offsets and region sizing.
package datasg_mc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DROP  = 2'd2
   } sg_state_e;

   localparam int DES_LSB = 0;

   function automatic int pri_lsb(input int des_w);
      return des_w;
   endfunction

   function automatic int len_lsb(input int des_w, input int pri_w);
      return des_w + pri_w;
   endfunction

   // Words per destination region: the SRAM is split evenly across ports.
   function automatic int region_words(input int addr_w, input int des_w);
      return 1 << (addr_w - des_w);
   endfunction

endpackage

// File: rtl/datasg_region_tracker.sv
// Per-port write pointer and occupancy bookkeeping for the SRAM regions.
module datasg_region_tracker
   import datasg_mc_pkg::*;
#(
   parameter int AW = 12,
   parameter int DW = 4,
   parameter int LW = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rsv_valid_i,
   input  logic [DW-1:0]    rsv_port_i,
   input  logic [LW-1:0]    rsv_len_i,
   input  logic             adv_valid_i,
   input  logic [DW-1:0]    adv_port_i,
   input  logic             rel_valid_i,
   input  logic [DW-1:0]    rel_port_i,
   input  logic [DW-1:0]    occ_port_i,
   output logic [AW-DW:0]   occ_o,
   input  logic [DW-1:0]    wptr_port_i,
   output logic [AW-DW-1:0] wptr_o
);

   localparam int WW = AW - DW;
   localparam int OW = WW + 1;
   localparam int NP = 1 << DW;

   logic [WW-1:0] wptr_q [NP];
   logic [OW-1:0] occ_q  [NP];
   logic [OW-1:0] rsv_amt_s;

   // Admission guarantees L fits in the region, so truncation never loses bits.
   assign rsv_amt_s = OW'(rsv_len_i);
   assign occ_o     = occ_q[occ_port_i];
   assign wptr_o    = wptr_q[wptr_port_i];

   // Pointer advance wraps naturally within the region; release at zero is ignored.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int p = 0; p < NP; p++) begin
            wptr_q[p] <= '0;
            occ_q[p]  <= '0;
         end
      end else begin
         for (int p = 0; p < NP; p++) begin
            if (adv_valid_i && (adv_port_i == DW'(p))) begin
               wptr_q[p] <= wptr_q[p] + WW'(1);
            end
            occ_q[p] <= occ_q[p]
                      + ((rsv_valid_i && (rsv_port_i == DW'(p))) ? rsv_amt_s : OW'(0))
                      - ((rel_valid_i && (rel_port_i == DW'(p)) && (occ_q[p] != OW'(0)))
                         ? OW'(1) : OW'(0));
         end
      end
   end

endmodule

// File: rtl/datasg_mc.sv
// Header-driven SRAM write controller: admits packets into per-port regions,
// issues one arbitrated write per payload word, and drops packets that do not fit.
module datasg_mc
   import datasg_mc_pkg::*;
#(
   parameter int SG_DATA_WIDTH     = 64,
   parameter int SG_ADDRESS_WIDTH  = 12,
   parameter int SG_DES_WIDTH      = 4,
   parameter int SG_PRIORITY_WIDTH = 3,
   parameter int SG_LEN_WIDTH      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [SG_DATA_WIDTH-1:0]     data_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         request,
   input  logic                         grant,
   output logic [SG_PRIORITY_WIDTH-1:0] wr_priority,
   output logic [SG_DES_WIDTH-1:0]      des_port,
   output logic [SG_ADDRESS_WIDTH-1:0]  address_write,
   output logic [SG_DATA_WIDTH-1:0]     data_write,
   input  logic                         release_valid,
   input  logic [SG_DES_WIDTH-1:0]      release_port,
   output logic [15:0]                  drop_cnt,
   output logic                         busy
);

   localparam int PRI_LSB = pri_lsb(SG_DES_WIDTH);
   localparam int LEN_LSB = len_lsb(SG_DES_WIDTH, SG_PRIORITY_WIDTH);
   localparam int R_WORDS = region_words(SG_ADDRESS_WIDTH, SG_DES_WIDTH);
   localparam int WW      = SG_ADDRESS_WIDTH - SG_DES_WIDTH;

   sg_state_e                    state_q, state_d;
   logic [SG_DES_WIDTH-1:0]      port_q, port_d, oport_q, oport_d;
   logic [SG_PRIORITY_WIDTH-1:0] pri_q, pri_d, opri_q, opri_d;
   logic [SG_LEN_WIDTH-1:0]      remain_q, remain_d;
   logic                         request_q, request_d;
   logic [SG_ADDRESS_WIDTH-1:0]  addr_q, addr_d;
   logic [SG_DATA_WIDTH-1:0]     data_q, data_d;
   logic [15:0]                  drop_cnt_q, drop_cnt_d;

   logic [SG_DES_WIDTH-1:0]      hdr_port_s;
   logic [SG_PRIORITY_WIDTH-1:0] hdr_pri_s;
   logic [SG_LEN_WIDTH-1:0]      hdr_len_s;
   logic [WW:0]                  occ_s;
   logic [WW-1:0]                wptr_s;
   logic                         fits_s, accept_s, in_ready_s, rsv_s, adv_s;

   assign hdr_port_s = data_in[DES_LSB +: SG_DES_WIDTH];
   assign hdr_pri_s  = data_in[PRI_LSB +: SG_PRIORITY_WIDTH];
   assign hdr_len_s  = data_in[LEN_LSB +: SG_LEN_WIDTH];
   // Admission uses the occupancy before any same-cycle release.
   assign fits_s     = (32'(hdr_len_s) + 32'(occ_s)) <= 32'(R_WORDS);
   assign accept_s   = in_valid && in_ready_s;

   datasg_region_tracker #(
      .AW (SG_ADDRESS_WIDTH),
      .DW (SG_DES_WIDTH),
      .LW (SG_LEN_WIDTH)
   ) u_tracker (
      .clk         (clk),
      .rst         (rst),
      .rsv_valid_i (rsv_s),
      .rsv_port_i  (hdr_port_s),
      .rsv_len_i   (hdr_len_s),
      .adv_valid_i (adv_s),
      .adv_port_i  (port_q),
      .rel_valid_i (release_valid),
      .rel_port_i  (release_port),
      .occ_port_i  (hdr_port_s),
      .occ_o       (occ_s),
      .wptr_port_i (port_q),
      .wptr_o      (wptr_s)
   );

   // Next-state and output-register loading; the pending write is held until grant.
   always_comb begin
      state_d    = state_q;
      port_d     = port_q;
      pri_d      = pri_q;
      remain_d   = remain_q;
      request_d  = request_q && !grant;
      addr_d     = addr_q;
      data_d     = data_q;
      opri_d     = opri_q;
      oport_d    = oport_q;
      drop_cnt_d = drop_cnt_q;
      in_ready_s = 1'b1;
      rsv_s      = 1'b0;
      adv_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s && (hdr_len_s != '0)) begin
               port_d   = hdr_port_s;
               pri_d    = hdr_pri_s;
               remain_d = hdr_len_s;
               if (fits_s) begin
                  state_d = ST_WRITE;
                  rsv_s   = 1'b1;
               end else begin
                  state_d = ST_DROP;
                  if (drop_cnt_q != 16'hFFFF) begin
                     drop_cnt_d = drop_cnt_q + 16'd1;
                  end else begin
                     drop_cnt_d = drop_cnt_q;
                  end
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            in_ready_s = !request_q || grant;
            if (accept_s) begin
               request_d = 1'b1;
               addr_d    = {port_q, wptr_s};
               data_d    = data_in;
               opri_d    = pri_q;
               oport_d   = port_q;
               adv_s     = 1'b1;
               remain_d  = remain_q - SG_LEN_WIDTH'(1);
               if (remain_q == SG_LEN_WIDTH'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WRITE;
               end
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DROP: begin
            if (accept_s) begin
               remain_d = remain_q - SG_LEN_WIDTH'(1);
               if (remain_q == SG_LEN_WIDTH'(1)) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DROP;
               end
            end else begin
               state_d = ST_DROP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         port_q     <= '0;
         pri_q      <= '0;
         remain_q   <= '0;
         request_q  <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         opri_q     <= '0;
         oport_q    <= '0;
         drop_cnt_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         port_q     <= port_d;
         pri_q      <= pri_d;
         remain_q   <= remain_d;
         request_q  <= request_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         opri_q     <= opri_d;
         oport_q    <= oport_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign in_ready      = in_ready_s;
   assign request       = request_q;
   assign wr_priority   = opri_q;
   assign des_port      = oport_q;
   assign address_write = addr_q;
   assign data_write    = data_q;
   assign drop_cnt      = drop_cnt_q;
   assign busy          = (state_q != ST_IDLE) || request_q;

endmodule
